debouncer_array: RTL and testbench

DEBOUNCER_ARRAY -- requirements
Module: debouncer_array

---
 rtl/debouncer_array.sv | 78 +++++++
 tb/tb_debouncer_array.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/debouncer_array.sv
// debouncer_array: per-channel synchronised debouncers with edge capture,
// interrupt masking and an Avalon-MM register window.
module debouncer_array #(
  parameter int CHANNELS     = 4,
  parameter int CNT_WIDTH    = 20,
  parameter int STABLE_COUNT = 500000,
  parameter int EDGE_MODE    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  input  logic [1:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  logic [CHANNELS-1:0] sync1, sync2, level_d, level_next;
  logic [CHANNELS-1:0] edge_capture, irq_mask, sel, clr;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt, cnt_next;
  logic [31:0] rd_mux;
  logic unused_wdata;
  assign unused_wdata = ^writedata;
  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so it is cleared by any single cycle of agreement.
  always_comb begin
    cnt_next   = cnt;
    level_next = level_out;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sync2[i] == level_out[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == LAST) begin
        cnt_next[i]   = '0;
        level_next[i] = ~level_out[i];
      end else begin
        cnt_next[i] = cnt[i] + 1'b1;
      end
    end
  end
  assign sel = (EDGE_MODE == 0) ? rise_pulse :
               (EDGE_MODE == 1) ? fall_pulse : (rise_pulse | fall_pulse);
  assign clr = (write && address == 2'd1) ? writedata[CHANNELS-1:0] : '0;
  assign rd_mux = (address == 2'd0) ? 32'(level_out) :
                  (address == 2'd1) ? 32'(edge_capture) :
                  (address == 2'd2) ? 32'(irq_mask) : 32'(STABLE_COUNT);
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      cnt          <= '0;
      level_out    <= '0;
      level_d      <= '0;
      rise_pulse   <= '0;
      fall_pulse   <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      sync1        <= raw_in;
      sync2        <= sync1;
      cnt          <= cnt_next;
      level_out    <= level_next;
      level_d      <= level_out;
      rise_pulse   <= level_out & ~level_d;
      fall_pulse   <= ~level_out & level_d;
      edge_capture <= (edge_capture & ~clr) | sel;
      irq          <= |(edge_capture & irq_mask);
      if (write && address == 2'd2) irq_mask <= writedata[CHANNELS-1:0];
      if (read) readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_debouncer_array.sv
// tb_debouncer_array: randomized and directed stimulus against a windowed
// reference model, checked through a per-cycle scoreboard queue.
module tb_debouncer_array;
  localparam int CH = 4, SC = 4, EM = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [CH-1:0] raw_in = '0;
  logic [CH-1:0] level_out, rise_pulse, fall_pulse;
  logic [1:0] address = '0;
  logic read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0, readdata;
  logic irq;

  always #5 clk = ~clk;

  debouncer_array #(.CHANNELS(CH), .CNT_WIDTH(20), .STABLE_COUNT(SC), .EDGE_MODE(EM)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .level_out(level_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .address(address),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  typedef struct {
    logic [CH-1:0] lvl, rise, fall;
    logic          irq, rd_v;
    logic [31:0]   rd;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvl_p = '0;
  logic [CH-1:0] m_rise = '0, m_fall = '0, m_cap = '0, m_mask = '0;
  logic          m_irq = 1'b0;
  logic [31:0]   m_rd = '0;
  logic [CH-1:0] hist[$];
  logic [CH-1:0] cur = '0;

  // A level flips once the last SC synchronised samples all disagree with it.
  task automatic model(input logic [CH-1:0] r, input logic rst, input logic rd,
                       input logic wr, input logic [1:0] a, input logic [31:0] wd);
    logic [CH-1:0] nl, sel, clr, nmask;
    logic [31:0] nrd;
    logic all_diff;
    if (rst) begin
      {m_s1, m_s2, m_lvl, m_lvl_p, m_rise, m_fall, m_cap, m_mask} = '0;
      m_irq = 1'b0;
      m_rd = '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      nl = m_lvl;
      if (hist.size() >= SC)
        for (int c = 0; c < CH; c++) begin
          all_diff = 1'b1;
          for (int k = hist.size() - SC; k < hist.size(); k++)
            if (hist[k][c] == m_lvl[c]) all_diff = 1'b0;
          if (all_diff) nl[c] = ~m_lvl[c];
        end
      while (hist.size() > SC) void'(hist.pop_front());
      sel = (EM == 0) ? m_rise : (EM == 1) ? m_fall : (m_rise | m_fall);
      clr = (wr && a == 2'd1) ? wd[CH-1:0] : '0;
      nmask = (wr && a == 2'd2) ? wd[CH-1:0] : m_mask;
      case (a)
        2'd0: nrd = 32'(m_lvl);
        2'd1: nrd = 32'(m_cap);
        2'd2: nrd = 32'(m_mask);
        default: nrd = SC;
      endcase
      if (rd) m_rd = nrd;
      m_irq  = |(m_cap & m_mask);
      m_cap  = (m_cap & ~clr) | sel;
      m_mask = nmask;
      m_rise = m_lvl & ~m_lvl_p;
      m_fall = ~m_lvl & m_lvl_p;
      m_lvl_p = m_lvl;
      m_lvl  = nl;
      m_s2   = m_s1;
      m_s1   = r;
    end
  endtask

  task automatic cyc(input logic [CH-1:0] r, input logic rst, input logic rd,
                     input logic wr, input logic [1:0] a, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    raw_in = r; reset = rst; read = rd; write = wr; address = a; writedata = wd;
    model(r, rst, rd, wr, a, wd);
    e.lvl = m_lvl; e.rise = m_rise; e.fall = m_fall; e.irq = m_irq;
    e.rd_v = rd; e.rd = m_rd;
    sb.push_back(e);
  endtask

  task automatic hold(input int n);
    repeat (n) cyc(cur, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask
  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    cyc(cur, 1'b0, 1'b0, 1'b1, a, d);
  endtask
  task automatic rreg(input logic [1:0] a);
    cyc(cur, 1'b0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("level_out", 32'(level_out), 32'(e.lvl));
      chk("rise_pulse", 32'(rise_pulse), 32'(e.rise));
      chk("fall_pulse", 32'(fall_pulse), 32'(e.fall));
      chk("irq", 32'(irq), 32'(e.irq));
      if (e.rd_v) chk("readdata", readdata, e.rd);
    end
  end

  initial begin
    logic [CH-1:0] r;
    logic rst, rd, wr;
    repeat (3) cyc('0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
    rreg(2'd1);
    cur[0] = 1'b1; hold(10); rreg(2'd1); rreg(2'd0); hold(1);
    cur[1] = 1'b1; hold(3); cur[1] = 1'b0; hold(10); rreg(2'd0); rreg(2'd1);
    wreg(2'd1, 32'hF); wreg(2'd2, 32'h1); rreg(2'd2);
    cur[0] = 1'b0; hold(12); wreg(2'd1, 32'h1); hold(3);
    cur[2] = 1'b1; hold(12); rreg(2'd1); hold(1);
    cur[0] = 1'b1; hold(7); wreg(2'd1, 32'h1); hold(1); rreg(2'd1); hold(1);
    cur[3] = 1'b1; hold(4); cyc(cur, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0); hold(10); rreg(2'd1);
    rreg(2'd3); hold(1);
    wreg(2'd0, 32'hFFFF_FFFF); wreg(2'd3, 32'h0); rreg(2'd3); rreg(2'd0); hold(1);
    for (int i = 0; i < 3000; i++) begin
      r = cur;
      for (int c = 0; c < CH; c++) if ($urandom_range(7) == 0) r[c] = ~r[c];
      cur = r;
      rst = ($urandom_range(499) == 0);
      rd  = ($urandom_range(3) == 0);
      wr  = ($urandom_range(5) == 0);
      cyc(cur, rst, rd, wr, 2'($urandom_range(3)), $urandom);
    end
    hold(2);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
